async_fifo_rd_ctrl: RTL and testbench
=====================================

Name: async_fifo_rd_ctrl

Overview:
Read-domain controller for the dual-clock FIFO. Successor to the existing read-pointer controller. It generalises pointer width and synchroniser depth, and adds an integrated write-pointer synchroniser, an almost-empty threshold and a selectable first-word-fall-through (FWFT) mode. It drives the read port of the shared dual-port RAM and exports its Gray read pointer to the write-side controller.

Parameters:
DATA_SIZE, 16, data width.
DEPTH_SIZE, 10, address bits; FIFO depth = 2^DEPTH_SIZE.
SYNC_STAGES, 2, flops in the wr_pointer synchroniser (legal range 2..4).
ALMOST_EMPTY_THR, 4, almost_empty asserts when readable count <= this value.
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through.

Ports:
rd_clk  in  1  read clock
rst_n  in  1  asynchronous, active-low reset
rd_en  in  1  read request / pop (FWFT: consume head)
wr_pointer  in  DEPTH_SIZE+1  Gray write pointer, write-clock domain (unsynchronised)
ram_rdata  in  DATA_SIZE  RAM read data, valid one rd_clk after ram_rd_en
rd_pointer  out  DEPTH_SIZE+1  registered Gray read pointer, to write side
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  DEPTH_SIZE  RAM read address = rd_bin[DEPTH_SIZE-1:0]
rd_data  out  DATA_SIZE  read data
rd_valid  out  1  rd_data valid
empty  out  1  no word readable from RAM
almost_empty  out  1  rd_data_count <= ALMOST_EMPTY_THR
rd_data_count  out  DEPTH_SIZE+1  words in RAM not yet popped
underflow  out  1  sticky; present only with RD_UNDERFLOW_EN

Behaviour:
- Reset values: rd_bin=0, rd_pointer=0, synchroniser flops=0, empty=1, almost_empty=1, rd_data_count=0, rd_valid=0, rd_data=0, underflow=0, FWFT buffer cleared.
- Reset is asserted asynchronously and deasserted synchronously (two-flop) inside the block. Reset mid-operation discards all buffered/in-flight data.
- Sync: wr_pointer passes through SYNC_STAGES flops to give wr_sync. No other cross-domain path exists.
- Pop: pop = issue & ~empty. rd_bin_next = rd_bin + pop; rd_gray_next = (rd_bin_next>>1)^rd_bin_next. Both are registered each cycle.
- empty <= (rd_gray_next == wr_sync). Wrap handled by the extra MSB, since the pointer is DEPTH_SIZE+1 bits.
- rd_data_count <= gray2bin(wr_sync) - rd_bin_next, modulo 2^(DEPTH_SIZE+1). almost_empty <= (that value <= ALMOST_EMPTY_THR).
- ram_rd_en = pop; ram_rd_addr = rd_bin[DEPTH_SIZE-1:0] (combinational from registers).
- FWFT=0: issue = rd_en. rd_valid <= pop; rd_data = ram_rdata. rd_en while empty is ignored: no pointer move, rd_valid stays 0.
- FWFT=1: 2-entry output skid buffer, head = rd_data, rd_valid = buffer non-empty.
  - consume = rd_en & rd_valid.
  - n = held entries + read in flight (0..2).
  - issue = ((n - consume) < 2).
  - RAM data is written into the buffer the cycle after pop.
  - First word reaches rd_valid 2 rd_clk after empty falls. Sustains one word per cycle thereafter.
  - rd_en with rd_valid=0 is ignored.
- FWFT=1: rd_data_count and almost_empty exclude words held or in flight in the skid buffer. empty refers to RAM only; users watch rd_valid.
- Simultaneous consume and landing: head advances, landing word is appended, order is preserved.
- Pointer wrap past 2^(DEPTH_SIZE+1)-1 returns to 0 seamlessly.

Optional Feature:
- Macro: RD_UNDERFLOW_EN.
- Defined: port underflow exists. It sets the cycle after a read attempt with nothing readable (FWFT=0: rd_en & empty; FWFT=1: rd_en & ~rd_valid). It holds until reset.
- Undefined: port and logic are absent. Illegal reads are silently ignored.

Decomposition:
- Shared package fifo_pkg: functions bin2gray and gray2bin (width-generic); FWFT buffer depth constant (2).
- Sub-module fifo_ptr_sync: SYNC_STAGES-deep, DEPTH_SIZE+1-bit synchroniser. The write-side controller reuses it for rd_pointer.

Test Plan:
- Reset, no writes → empty=1, almost_empty=1, rd_data_count=0, rd_valid=0; rd_en pulsed → rd_pointer stays 0.
- FWFT=0: wr_pointer stepped through Gray 0→1→2→3 (3 words) → empty falls SYNC_STAGES+1 cycles later, count=3. Three rd_en cycles → ram_rd_addr 0,1,2; rd_valid one cycle after each; empty=1 after the third; count=0.
- ALMOST_EMPTY_THR=4, 6 words written → almost_empty=0. Pop 2 → almost_empty=1 with count=4.
- FWFT=1, 8 words, rd_en held high → rd_valid rises 2 cycles after empty falls. 8 consecutive valid words, no bubble, in order; rd_valid falls after the eighth.
- DEPTH_SIZE=3: write/read 20 words total in bursts → rd_pointer wraps at 16. Gray sequence stays single-bit-change, data order is correct, count never exceeds 8.
- RD_UNDERFLOW_EN defined: rd_en while empty → underflow=1 next cycle and stays 1; rst_n low → clears to 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers.
// Provides width-generic Gray conversion and the FWFT skid-buffer depth.
package fifo_pkg;

    localparam int PTR_MAX_W  = 32;
    localparam int FWFT_DEPTH = 2;

    // Callers zero-extend narrower pointers and truncate the result back.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded FIFO pointer crossing clock domains.
// Shared by the read-side and write-side controllers.
module fifo_ptr_sync #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: pointer, flags, count, optional FWFT skid buffer.
// Optional sticky underflow port is built when RD_UNDERFLOW_EN is defined.
module async_fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE        = 16,
    parameter int DEPTH_SIZE       = 10,
    parameter int SYNC_STAGES      = 2,
    parameter int ALMOST_EMPTY_THR = 4,
    parameter int FWFT             = 0
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DEPTH_SIZE:0]   wr_pointer,
    input  logic [DATA_SIZE-1:0]  ram_rdata,
    output logic [DEPTH_SIZE:0]   rd_pointer,
    output logic                  ram_rd_en,
    output logic [DEPTH_SIZE-1:0] ram_rd_addr,
    output logic [DATA_SIZE-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_SIZE:0]   rd_data_count
`ifdef RD_UNDERFLOW_EN
    ,
    output logic                  underflow
`endif
);

    localparam int               PTR_W  = DEPTH_SIZE + 1;
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(ALMOST_EMPTY_THR);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [PTR_W-1:0] w_wr_sync;
    logic [PTR_W-1:0] w_wr_bin;
    logic [PTR_W-1:0] w_rd_bin_next;
    logic [PTR_W-1:0] w_rd_gray_next;
    logic [PTR_W-1:0] w_count_next;
    logic [PTR_W-1:0] r_rd_bin;
    logic [PTR_W-1:0] r_rd_gray;
    logic [PTR_W-1:0] r_count;
    logic             r_empty;
    logic             r_almost_empty;
    logic             w_issue;
    logic             w_pop;

    // Reset asserts immediately but releases only after two clean rd_clk edges.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    fifo_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .i_clk   (rd_clk),
        .i_rst_n (w_rst_n),
        .i_d     (wr_pointer),
        .o_q     (w_wr_sync)
    );

    assign w_pop          = w_issue & ~r_empty;
    assign w_rd_bin_next  = r_rd_bin + PTR_W'(w_pop);
    assign w_rd_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(w_rd_bin_next)));
    assign w_wr_bin       = PTR_W'(gray2bin(PTR_MAX_W'(w_wr_sync)));
    assign w_count_next   = w_wr_bin - w_rd_bin_next;

    always_ff @(posedge rd_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_bin       <= '0;
            r_rd_gray      <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
        end else begin
            r_rd_bin       <= w_rd_bin_next;
            r_rd_gray      <= w_rd_gray_next;
            r_count        <= w_count_next;
            r_empty        <= (w_rd_gray_next == w_wr_sync);
            r_almost_empty <= (w_count_next <= AE_THR);
        end
    end

    assign rd_pointer    = r_rd_gray;
    assign rd_data_count = r_count;
    assign empty         = r_empty;
    assign almost_empty  = r_almost_empty;
    assign ram_rd_en     = w_pop;
    assign ram_rd_addr   = r_rd_bin[DEPTH_SIZE-1:0];

    generate
        if (FWFT == 0) begin : g_std
            logic r_valid;

            assign w_issue = rd_en;

            always_ff @(posedge rd_clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_pop;
                end
            end

            assign rd_valid = r_valid;
            assign rd_data  = ram_rdata;
        end else begin : g_fwft
            logic [DATA_SIZE-1:0] r_buf [FWFT_DEPTH];
            logic [1:0]           r_held;
            logic                 r_inflight;
            logic                 w_consume;
            logic [1:0]           w_n;
            logic [1:0]           w_after;
            logic [DATA_SIZE-1:0] w_buf0_next;
            logic [DATA_SIZE-1:0] w_buf1_next;

            // Keep fetching while the buffer plus the word in flight would stay under two.
            assign w_consume = rd_en & (r_held != 2'd0);
            assign w_n       = r_held + {1'b0, r_inflight};
            assign w_issue   = ((w_n - {1'b0, w_consume}) < 2'd2);
            assign w_after   = r_held - {1'b0, w_consume};

            always_comb begin
                w_buf0_next = w_consume ? r_buf[1] : r_buf[0];
                w_buf1_next = r_buf[1];
                if (r_inflight) begin
                    if (w_after == 2'd0) begin
                        w_buf0_next = ram_rdata;
                    end else begin
                        w_buf1_next = ram_rdata;
                    end
                end
            end

            always_ff @(posedge rd_clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_buf[0]   <= '0;
                    r_buf[1]   <= '0;
                    r_held     <= '0;
                    r_inflight <= 1'b0;
                end else begin
                    r_buf[0]   <= w_buf0_next;
                    r_buf[1]   <= w_buf1_next;
                    r_held     <= w_after + {1'b0, r_inflight};
                    r_inflight <= w_pop;
                end
            end

            assign rd_valid = (r_held != 2'd0);
            assign rd_data  = r_buf[0];
        end
    endgenerate

`ifdef RD_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge rd_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow | (rd_en & ((FWFT == 0) ? r_empty : ~rd_valid));
        end
    end

    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: a standard-read and an FWFT instance (DEPTH_SIZE=3), each with
// its own bench-side write pointer and RAM, checked every cycle against a count/queue model.
module tb_async_fifo_rd_ctrl;

    localparam int DW   = 16;
    localparam int DS   = 3;
    localparam int PW   = DS + 1;
    localparam int SYNC = 2;
    localparam int THR  = 4;
    localparam int NCH  = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          rdEn        [NCH];
    logic [PW-1:0] wrPtr       [NCH];
    logic [DW-1:0] ramRdata    [NCH];
    logic [PW-1:0] rdPtr       [NCH];
    logic          ramRdEn     [NCH];
    logic [DS-1:0] ramRdAddr   [NCH];
    logic [DW-1:0] rdData      [NCH];
    logic          rdValid     [NCH];
    logic          emptyO      [NCH];
    logic          almostEmpty [NCH];
    logic [PW-1:0] rdCount     [NCH];
`ifdef RD_UNDERFLOW_EN
    logic          underflowO  [NCH];
`endif
    logic [DW-1:0] mem [NCH][1<<DS];

    int checks = 0;
    int errors = 0;

    int            wCnt   [NCH];
    int            rCnt   [NCH];
    int            syncQ  [NCH][SYNC];
    bit            mEmpty [NCH];
    int            mCount [NCH];
    bit            mUf    [NCH];
    bit            mValid0;
    logic [DW-1:0] mData0;
    logic [DW-1:0] hq [$];
    bit            inflight;
    logic [DW-1:0] inflData;
    int            rstHold = 2;

    always #5 clk = ~clk;

    async_fifo_rd_ctrl #(
        .DATA_SIZE(DW), .DEPTH_SIZE(DS), .SYNC_STAGES(SYNC), .ALMOST_EMPTY_THR(THR), .FWFT(0)
    ) dutStd (
        .rd_clk(clk), .rst_n(rstN), .rd_en(rdEn[0]), .wr_pointer(wrPtr[0]), .ram_rdata(ramRdata[0]),
        .rd_pointer(rdPtr[0]), .ram_rd_en(ramRdEn[0]), .ram_rd_addr(ramRdAddr[0]), .rd_data(rdData[0]),
        .rd_valid(rdValid[0]), .empty(emptyO[0]), .almost_empty(almostEmpty[0]), .rd_data_count(rdCount[0])
`ifdef RD_UNDERFLOW_EN
        , .underflow(underflowO[0])
`endif
    );

    async_fifo_rd_ctrl #(
        .DATA_SIZE(DW), .DEPTH_SIZE(DS), .SYNC_STAGES(SYNC), .ALMOST_EMPTY_THR(THR), .FWFT(1)
    ) dutFwft (
        .rd_clk(clk), .rst_n(rstN), .rd_en(rdEn[1]), .wr_pointer(wrPtr[1]), .ram_rdata(ramRdata[1]),
        .rd_pointer(rdPtr[1]), .ram_rd_en(ramRdEn[1]), .ram_rd_addr(ramRdAddr[1]), .rd_data(rdData[1]),
        .rd_valid(rdValid[1]), .empty(emptyO[1]), .almost_empty(almostEmpty[1]), .rd_data_count(rdCount[1])
`ifdef RD_UNDERFLOW_EN
        , .underflow(underflowO[1])
`endif
    );

    // Dual-port RAM read port: registered, one cycle after the strobe.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (ramRdEn[c]) ramRdata[c] <= mem[c][ramRdAddr[c]];
        end
    end

    function automatic logic [PW-1:0] toGray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (1 << PW));
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DW-1:0] dataOf(input int i);
        return DW'(32'h5A00 + i * 13);
    endfunction

    function automatic bit expectPop(input int c);
        bit consume;
        bit issue;
        int n;
        if (c == 0) begin
            issue = rdEn[0];
        end else begin
            consume = rdEn[1] && (hq.size() > 0);
            n = hq.size() + int'(inflight);
            issue = (n - int'(consume)) < 2;
        end
        return issue && !mEmpty[c];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advance at each rising edge, using the inputs as they stood before the edge.
    task automatic modelStep();
        int wsync;
        bit pop;
        bit consume;
        if (!rstN || rstHold > 0) begin
            if (!rstN) rstHold = 2;
            else rstHold--;
            for (int c = 0; c < NCH; c++) begin
                rCnt[c] = 0;
                mEmpty[c] = 1'b1;
                mCount[c] = 0;
                mUf[c] = 1'b0;
                for (int k = 0; k < SYNC; k++) syncQ[c][k] = 0;
            end
            mValid0 = 1'b0;
            mData0 = '0;
            hq.delete();
            inflight = 1'b0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            wsync = syncQ[c][SYNC-1];
            pop = expectPop(c);
            if (c == 0) begin
                if (rdEn[0] && mEmpty[0]) mUf[0] = 1'b1;
                mValid0 = pop;
                mData0 = dataOf(rCnt[0]);
            end else begin
                consume = rdEn[1] && (hq.size() > 0);
                if (rdEn[1] && hq.size() == 0) mUf[1] = 1'b1;
                if (consume) void'(hq.pop_front());
                if (inflight) hq.push_back(inflData);
                inflight = pop;
                inflData = dataOf(rCnt[1]);
            end
            if (pop) rCnt[c]++;
            mEmpty[c] = (wsync == rCnt[c]);
            mCount[c] = wsync - rCnt[c];
            for (int k = SYNC - 1; k > 0; k--) syncQ[c][k] = syncQ[c][k-1];
            syncQ[c][0] = wCnt[c];
        end
    endtask

    task automatic compareAll();
        bit expValid;
        if (!rstN) return;
        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("ch%0d rd_pointer", c), rdPtr[c], toGray(rCnt[c]));
            checkOutput($sformatf("ch%0d empty", c), emptyO[c], mEmpty[c]);
            checkOutput($sformatf("ch%0d almost_empty", c), almostEmpty[c], mCount[c] <= THR);
            checkOutput($sformatf("ch%0d rd_data_count", c), rdCount[c], mCount[c]);
            checkOutput($sformatf("ch%0d count bound", c), rdCount[c] <= 8, 1);
            checkOutput($sformatf("ch%0d ram_rd_en", c), ramRdEn[c], expectPop(c));
            checkOutput($sformatf("ch%0d ram_rd_addr", c), ramRdAddr[c], rCnt[c] % (1 << DS));
            expValid = (c == 0) ? mValid0 : (hq.size() > 0);
            checkOutput($sformatf("ch%0d rd_valid", c), rdValid[c], expValid);
            if (expValid) begin
                checkOutput($sformatf("ch%0d rd_data", c), rdData[c], (c == 0) ? mData0 : hq[0]);
            end
`ifdef RD_UNDERFLOW_EN
            checkOutput($sformatf("ch%0d underflow", c), underflowO[c], mUf[c]);
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        compareAll();
    end

    // One cycle of stimulus: inputs change just after the rising edge.
    task automatic applyStimulus(input bit rd0, input bit rd1, input bit wr0, input bit wr1);
        bit wr [NCH];
        @(posedge clk);
        #1;
        rdEn[0] = rd0;
        rdEn[1] = rd1;
        wr[0] = wr0;
        wr[1] = wr1;
        for (int c = 0; c < NCH; c++) begin
            if (wr[c]) begin
                mem[c][wCnt[c] % (1 << DS)] = dataOf(wCnt[c]);
                wCnt[c]++;
                wrPtr[c] = toGray(wCnt[c]);
            end
        end
    endtask

    initial begin
        int emptyFall;
        int validRise;
        int validCount;
        int lastValid;
        rstN = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rdEn[c] = 1'b0;
            wrPtr[c] = '0;
            wCnt[c] = 0;
            for (int a = 0; a < (1 << DS); a++) mem[c][a] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (4) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset empty", emptyO[0], 1);
        checkOutput("reset almost_empty", almostEmpty[0], 1);
        checkOutput("reset count", rdCount[0], 0);
        checkOutput("reset rd_valid std", rdValid[0], 0);
        checkOutput("reset rd_valid fwft", rdValid[1], 0);

        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("empty read ptr std", rdPtr[0], 0);
        checkOutput("empty read ptr fwft", rdPtr[1], 0);
`ifdef RD_UNDERFLOW_EN
        checkOutput("underflow set std", underflowO[0], 1);
        checkOutput("underflow set fwft", underflowO[1], 1);
`endif

        repeat (3) applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("three words count", rdCount[0], 3);
        checkOutput("three words empty", emptyO[0], 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0);
            @(negedge clk);
            checkOutput("std read addr", ramRdAddr[0], i);
            if (i > 0) checkOutput("std read data", rdData[0], dataOf(i - 1));
        end
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("std last valid", rdValid[0], 1);
        checkOutput("std last data", rdData[0], dataOf(2));
        checkOutput("std drained empty", emptyO[0], 1);
        checkOutput("std drained count", rdCount[0], 0);

        repeat (6) applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("six words count", rdCount[0], 6);
        checkOutput("six words almost_empty", almostEmpty[0], 0);
        repeat (2) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("after pop2 count", rdCount[0], 4);
        checkOutput("after pop2 almost_empty", almostEmpty[0], 1);
        repeat (4) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("std drained again", emptyO[0], 1);

        emptyFall = -1;
        validRise = -1;
        validCount = 0;
        lastValid = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            applyStimulus(0, 1, 0, cyc < 8);
            @(negedge clk);
            if (emptyFall < 0 && !emptyO[1]) emptyFall = cyc;
            if (rdValid[1]) begin
                if (validRise < 0) validRise = cyc;
                checkOutput("fwft order", rdData[1], dataOf(validCount));
                validCount++;
                lastValid = cyc;
            end
        end
        checkOutput("fwft latency", validRise - emptyFall, 2);
        checkOutput("fwft word count", validCount, 8);
        checkOutput("fwft no bubble", lastValid - validRise + 1, 8);

        for (int b = 0; b < 4; b++) begin
            repeat (5) applyStimulus(0, 0, 1, 1);
            repeat (12) applyStimulus(1, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap ptr std", rdPtr[0], 4'hB);
        checkOutput("wrap ptr fwft", rdPtr[1], 4'hA);
        checkOutput("wrap empty std", emptyO[0], 1);
        checkOutput("wrap empty fwft", emptyO[1], 1);

        repeat (3) applyStimulus(0, 0, 1, 1);
        repeat (4) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pre-reset count std", rdCount[0], 3);
        checkOutput("pre-reset count fwft", rdCount[1], 1);
        checkOutput("pre-reset valid fwft", rdValid[1], 1);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            wCnt[c] = 0;
            wrPtr[c] = '0;
        end
        @(negedge clk);
        checkOutput("async reset empty", emptyO[0], 1);
        checkOutput("async reset count", rdCount[0], 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (4) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("post-reset ptr std", rdPtr[0], 0);
        checkOutput("post-reset ptr fwft", rdPtr[1], 0);
        checkOutput("post-reset valid fwft", rdValid[1], 0);
        checkOutput("post-reset count fwft", rdCount[1], 0);
`ifdef RD_UNDERFLOW_EN
        checkOutput("underflow cleared std", underflowO[0], 0);
        checkOutput("underflow cleared fwft", underflowO[1], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
